video_timing_ctrl: RTL and testbench

- Timing and configuration sequencer that drives the video mixer / scandoubler path.
- Divides clk_sys into the pixel strobes the mixer expects and counts horizontal and vertical position.
- Generates HSync, VSync and line_start.
- Shadows the user video configuration (scanlines, scandoubler bypass, hq2x, YPbPr, mono), so changes land only on a frame boundary and never mid-frame.

---
 rtl/video_timing_pkg.sv | 26 ++
 rtl/video_pix_ce_gen.sv | 38 +++
 rtl/video_timing_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_video_timing_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing / config sequencer:
// config field layout, config FSM states and raster window helper.
package video_timing_pkg;

  localparam int CFG_W             = 7;
  localparam int CFG_SCANLINES_MSB = 6;
  localparam int CFG_SCANLINES_LSB = 5;
  localparam int CFG_SD_DISABLE    = 4;
  localparam int CFG_HQ2X          = 3;
  localparam int CFG_YPBPR         = 2;
  localparam int CFG_YPBPR_FULL    = 1;
  localparam int CFG_MONO          = 0;

  // No scanlines, scandoubler on, RGB, colour.
  localparam logic [CFG_W-1:0] CFG_DEFAULT = 7'b0000000;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

  function automatic logic in_window(input logic [8:0] pos, input int start, input int len);
    return (int'(pos) >= start) && (int'(pos) < start + len);
  endfunction

endpackage

// File: rtl/video_pix_ce_gen.sv
// Clock-enable divider: native pixel strobe every CE_DIV clocks and a
// double-rate strobe every CE_DIV/2 clocks, both registered.
module video_pix_ce_gen #(
  parameter int CE_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_ce_pix,
  output logic o_ce_pix_actual,
  output logic o_ce_next
);

  localparam int CW = $clog2(CE_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CE_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CE_DIV / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          w_zero;

  assign w_zero    = (r_cnt == {CW{1'b0}});
  // The strobe registers fire the cycle after the counter sits at 0.
  assign o_ce_next = w_zero;

  // Divider counter and registered strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt           <= {CW{1'b0}};
      o_ce_pix        <= 1'b0;
      o_ce_pix_actual <= 1'b0;
    end else begin
      r_cnt           <= (r_cnt == CNT_LAST) ? {CW{1'b0}} : r_cnt + CNT_ONE;
      o_ce_pix        <= w_zero | (r_cnt == CNT_HALF);
      o_ce_pix_actual <= w_zero;
    end
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing (pixel strobes, counters, syncs) plus frame-synchronous video config shadow.
// Optional HBlank/VBlank outputs are built when VIDEO_TIMING_CTRL_BLANK_EN is defined.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int CE_DIV       = 4,
  parameter int H_TOTAL      = 448,
  parameter int H_SYNC_START = 344,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_TOTAL      = 312,
  parameter int V_SYNC_START = 248,
  parameter int V_SYNC_LEN   = 4
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [CFG_W-1:0] cfg_in,
  input  logic             cfg_wr,
  output logic             ce_pix,
  output logic             ce_pix_actual,
  output logic             line_start,
  output logic             HSync,
  output logic             VSync,
  output logic [8:0]       hcount,
  output logic [8:0]       vcount,
  output logic [CFG_W-1:0] cfg_out,
  output logic             cfg_pending
`ifdef VIDEO_TIMING_CTRL_BLANK_EN
  ,
  output logic             HBlank,
  output logic             VBlank
`endif
);

  localparam logic [8:0] H_LAST    = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST    = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_SYNC_AT = 9'(V_SYNC_START);

  logic             w_ce_pix;
  logic             w_ce_pix_actual;
  logic             w_ce_next;
  logic             w_h_wrap;
  logic [8:0]       w_h_next;
  logic [8:0]       w_v_next;
  logic             w_commit;

  logic [8:0]       r_hcount;
  logic [8:0]       r_vcount;
  logic             r_line_start;
  logic             r_hsync;
  logic             r_vsync;

  cfg_state_t       r_state;
  cfg_state_t       w_state_next;
  logic [CFG_W-1:0] r_shadow;
  logic [CFG_W-1:0] w_shadow_next;
  logic [CFG_W-1:0] r_cfg_out;
  logic [CFG_W-1:0] w_cfg_out_next;
  logic             r_pending;
  logic             w_pending_next;

  video_pix_ce_gen #(
    .CE_DIV (CE_DIV)
  ) u_ce_gen (
    .i_clk           (clk_sys),
    .i_rst_n         (reset_n),
    .o_ce_pix        (w_ce_pix),
    .o_ce_pix_actual (w_ce_pix_actual),
    .o_ce_next       (w_ce_next)
  );

  // Next raster position and the frame-boundary commit event (VSync rising edge).
  always_comb begin
    w_h_wrap = (r_hcount == H_LAST);
    w_h_next = w_h_wrap ? 9'd0 : r_hcount + 9'd1;
    if (w_h_wrap) begin
      w_v_next = (r_vcount == V_LAST) ? 9'd0 : r_vcount + 9'd1;
    end else begin
      w_v_next = r_vcount;
    end
    w_commit = w_ce_pix_actual & w_h_wrap & (w_v_next == V_SYNC_AT);
  end

  // Counters and syncs advance at the end of each pixel strobe cycle, so syncs track the counters.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hcount     <= 9'd0;
      r_vcount     <= 9'd0;
      r_line_start <= 1'b0;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
    end else begin
      // The strobe never coincides with w_ce_next, so hcount is stable into the next strobe.
      r_line_start <= w_ce_next & (r_hcount == 9'd0);
      if (w_ce_pix_actual) begin
        r_hcount <= w_h_next;
        r_vcount <= w_v_next;
        r_hsync  <= in_window(w_h_next, H_SYNC_START, H_SYNC_LEN);
        r_vsync  <= in_window(w_v_next, V_SYNC_START, V_SYNC_LEN);
      end
    end
  end

`ifdef VIDEO_TIMING_CTRL_BLANK_EN
  localparam int HBLANK_START = (H_SYNC_START >= 16) ? H_SYNC_START - 16 : 0;
  localparam int VBLANK_START = (V_SYNC_START >= 8) ? V_SYNC_START - 8 : 0;

  logic r_hblank;
  logic r_vblank;

  // Blanking flags, registered with the syncs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hblank <= 1'b0;
      r_vblank <= 1'b0;
    end else if (w_ce_pix_actual) begin
      r_hblank <= (int'(w_h_next) >= HBLANK_START);
      r_vblank <= (int'(w_v_next) >= VBLANK_START);
    end
  end

  assign HBlank = r_hblank;
  assign VBlank = r_vblank;
`endif

  // Config FSM state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_shadow  <= CFG_DEFAULT;
      r_cfg_out <= CFG_DEFAULT;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shadow  <= w_shadow_next;
      r_cfg_out <= w_cfg_out_next;
      r_pending <= w_pending_next;
    end
  end

  // Config FSM next state: last write wins; a write on the commit edge is held for the next frame.
  always_comb begin
    w_state_next   = r_state;
    w_shadow_next  = r_shadow;
    w_cfg_out_next = r_cfg_out;
    w_pending_next = r_pending;
    case (r_state)
      IDLE: begin
        if (cfg_wr) begin
          w_shadow_next  = cfg_in;
          w_pending_next = 1'b1;
          w_state_next   = PENDING;
        end else begin
          w_pending_next = 1'b0;
        end
      end
      PENDING: begin
        if (w_commit) begin
          w_cfg_out_next = r_shadow;
          if (cfg_wr) begin
            w_shadow_next  = cfg_in;
            w_pending_next = 1'b1;
            w_state_next   = PENDING;
          end else begin
            w_pending_next = 1'b0;
            w_state_next   = IDLE;
          end
        end else if (cfg_wr) begin
          w_shadow_next = cfg_in;
        end else begin
          w_pending_next = 1'b1;
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_pending_next = 1'b0;
      end
    endcase
  end

  assign ce_pix        = w_ce_pix;
  assign ce_pix_actual = w_ce_pix_actual;
  assign line_start    = r_line_start;
  assign HSync         = r_hsync;
  assign VSync         = r_vsync;
  assign hcount        = r_hcount;
  assign vcount        = r_vcount;
  assign cfg_out       = r_cfg_out;
  assign cfg_pending   = r_pending;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl on a scaled-down raster (16x12 pixels, CE_DIV=4),
// so whole frames and several config commits fit in a short run.
module tb_video_timing_ctrl;

  localparam int CE_DIV = 4;
  localparam int H_TOT  = 16;
  localparam int HSS    = 10;
  localparam int HSL    = 3;
  localparam int V_TOT  = 12;
  localparam int VSS    = 8;
  localparam int VSL    = 2;
  localparam int LINE_CLKS  = H_TOT * CE_DIV;
  localparam int FRAME_CLKS = H_TOT * V_TOT * CE_DIV;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [6:0] cfg_in;
  logic       cfg_wr;
  logic       ce_pix;
  logic       ce_pix_actual;
  logic       line_start;
  logic       HSync;
  logic       VSync;
  logic [8:0] hcount;
  logic [8:0] vcount;
  logic [6:0] cfg_out;
  logic       cfg_pending;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int last_ls = 0;
  int last_fs = 0;
  int vs_cycles = 0;
  int hs_cycles = 0;

  video_timing_ctrl #(
    .CE_DIV       (CE_DIV),
    .H_TOTAL      (H_TOT),
    .H_SYNC_START (HSS),
    .H_SYNC_LEN   (HSL),
    .V_TOTAL      (V_TOT),
    .V_SYNC_START (VSS),
    .V_SYNC_LEN   (VSL)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .cfg_in        (cfg_in),
    .cfg_wr        (cfg_wr),
    .ce_pix        (ce_pix),
    .ce_pix_actual (ce_pix_actual),
    .line_start    (line_start),
    .HSync         (HSync),
    .VSync         (VSync),
    .hcount        (hcount),
    .vcount        (vcount),
    .cfg_out       (cfg_out),
    .cfg_pending   (cfg_pending)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ce_pix"},      32'(ce_pix),        32'd0);
    chk({tag, "_ce_act"},      32'(ce_pix_actual), 32'd0);
    chk({tag, "_line_start"},  32'(line_start),    32'd0);
    chk({tag, "_hsync"},       32'(HSync),         32'd0);
    chk({tag, "_vsync"},       32'(VSync),         32'd0);
    chk({tag, "_hcount"},      32'(hcount),        32'd0);
    chk({tag, "_vcount"},      32'(vcount),        32'd0);
    chk({tag, "_cfg_out"},     32'(cfg_out),       32'd0);
    chk({tag, "_cfg_pending"}, 32'(cfg_pending),   32'd0);
  endtask

  // Expected raster state as a closed form of clocks elapsed since reset release.
  task automatic check_timing();
    int   n, h, v, ph;
    logic e_act, e_pix, e_ls, e_hs, e_vs;
    n     = (cyc + CE_DIV - 2) / CE_DIV;
    h     = n % H_TOT;
    v     = (n / H_TOT) % V_TOT;
    ph    = cyc % CE_DIV;
    e_act = (cyc > 0) && (ph == 1);
    e_pix = (cyc > 0) && ((ph == 1) || (ph == 1 + CE_DIV / 2));
    e_ls  = e_act && (h == 0);
    e_hs  = (h >= HSS) && (h < HSS + HSL);
    e_vs  = (v >= VSS) && (v < VSS + VSL);
    chk("ce_pix_actual", 32'(ce_pix_actual), 32'(e_act));
    chk("ce_pix",        32'(ce_pix),        32'(e_pix));
    chk("line_start",    32'(line_start),    32'(e_ls));
    chk("hcount",        32'(hcount),        32'(h));
    chk("vcount",        32'(vcount),        32'(v));
    chk("HSync",         32'(HSync),         32'(e_hs));
    chk("VSync",         32'(VSync),         32'(e_vs));
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    cyc++;
    check_timing();
    if (cyc <= FRAME_CLKS && VSync === 1'b1) vs_cycles++;
    if (cyc <= LINE_CLKS && HSync === 1'b1) hs_cycles++;
    if (line_start === 1'b1) begin
      if (last_ls != 0) chk("line_period", 32'(cyc - last_ls), 32'(LINE_CLKS));
      last_ls = cyc;
      if (vcount === 9'd0) begin
        if (last_fs != 0) chk("frame_period", 32'(cyc - last_fs), 32'(FRAME_CLKS));
        last_fs = cyc;
      end
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic write_cfg(input logic [6:0] val);
    cfg_in = val;
    cfg_wr = 1'b1;
    step();
    cfg_wr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_wr  = 1'b0;
    cfg_in  = 7'h00;
    repeat (3) @(posedge clk_sys);
    #1;
    check_all_zero("rst");
    reset_n = 1'b1;
    cyc     = 0;
    check_timing();

    // Divider start-up: strobes at clocks 1,5,9,13 and 3,7,11,15.
    run_to(1);
    chk("first_ce_act", 32'(ce_pix_actual), 32'd1);
    chk("first_ls",     32'(line_start),    32'd1);
    run_to(16);

    // Full frame: wrap of vcount, sync widths.
    run_to(765);
    chk("pre_wrap_h", 32'(hcount), 32'd15);
    chk("pre_wrap_v", 32'(vcount), 32'd11);
    run_to(766);
    chk("post_wrap_h", 32'(hcount), 32'd0);
    chk("post_wrap_v", 32'(vcount), 32'd0);
    run_to(FRAME_CLKS + 2);
    chk("hsync_cycles", 32'(hs_cycles), 32'(HSL * CE_DIV));
    chk("vsync_cycles", 32'(vs_cycles), 32'(VSL * LINE_CLKS));
    chk("frame_seen",   32'(last_fs),   32'(FRAME_CLKS + 1));

    // Single write commits on the next VSync rising edge (cycle 1278).
    run_to(1000);
    write_cfg(7'b1100001);
    chk("a_pending", 32'(cfg_pending), 32'd1);
    chk("a_out_hold", 32'(cfg_out), 32'd0);
    run_to(1277);
    chk("a_pre_commit_out", 32'(cfg_out), 32'd0);
    chk("a_pre_commit_pend", 32'(cfg_pending), 32'd1);
    run_to(1278);
    chk("a_commit_vsync", 32'(VSync), 32'd1);
    chk("a_commit_out", 32'(cfg_out), 32'h61);
    chk("a_commit_pend", 32'(cfg_pending), 32'd0);

    // Two writes in one frame: last one wins (commit at 2046).
    run_to(1500);
    write_cfg(7'h11);
    run_to(1600);
    write_cfg(7'h22);
    chk("b_pending", 32'(cfg_pending), 32'd1);
    chk("b_out_hold", 32'(cfg_out), 32'h61);
    run_to(2045);
    chk("b_pre_commit_out", 32'(cfg_out), 32'h61);
    run_to(2046);
    chk("b_commit_out", 32'(cfg_out), 32'h22);
    chk("b_commit_pend", 32'(cfg_pending), 32'd0);

    // Write landing on the commit edge (2814): old shadow commits, new one next frame (3582).
    run_to(2200);
    write_cfg(7'h33);
    run_to(2813);
    write_cfg(7'h44);
    chk("c_commit_out", 32'(cfg_out), 32'h33);
    chk("c_commit_pend", 32'(cfg_pending), 32'd1);
    run_to(3581);
    chk("c_hold_out", 32'(cfg_out), 32'h33);
    run_to(3582);
    chk("c_next_out", 32'(cfg_out), 32'h44);
    chk("c_next_pend", 32'(cfg_pending), 32'd0);

    // Mid-line reset with a pending write: everything clears asynchronously.
    run_to(3700);
    write_cfg(7'h55);
    chk("d_pending", 32'(cfg_pending), 32'd1);
    run_to(3720);
    chk("d_midline_h", 32'(hcount), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    cyc     = 0;
    last_ls = 0;
    last_fs = 0;
    check_timing();
    run_to(511);
    chk("d_discard_out", 32'(cfg_out), 32'd0);
    chk("d_discard_pend", 32'(cfg_pending), 32'd0);
    chk("d_vsync_after_rst", 32'(VSync), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
